rv32m_mdu: RTL and testbench
============================

Name: rv32m_mdu

Overview:
- Iterative RV32M multiply/divide unit.
- Sits directly downstream of the ALU source-A/source-B operand muxes, in parallel with the ALU. Consumes the same selected srcA/srcB operands.
- The control unit stalls on busy and writes result back on done.
- Radix-2, one bit per clock. No DSP inference required.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcA  input  XLEN  operand A (rs1 / dividend / multiplicand).
- srcB  input  XLEN  operand B (rs2 / divisor / multiplier).
- busy  output  1  high in CALC and FIX states.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result; held until the next accepted start completes.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (CLK, RST). Asserting RST at any time, including mid-operation, forces:
  - state=IDLE, busy=0, done=0, result=0, counter=0;
  - all internal datapath registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1: capture funct3 and operands.
  - Special divide cases go directly to DONE:
    - divisor==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
    - DIV/REM with A=0x80000000 and B=0xFFFFFFFF: DIV → 0x80000000, REM → 0.
  - All other ops go to CALC with counter=31:
    - Signed ops load the magnitudes: MULH/DIV/REM use |A| and |B|; MULHSU uses |A| and B unsigned.
    - Latch the result-sign flags:
      - product sign = sA XOR sB;
      - quotient sign = sA XOR sB;
      - remainder sign = sA.
- CALC:
  - Multiply: shift-add into a 64-bit accumulator, one multiplier bit per cycle.
  - Divide: restoring division producing one quotient bit per cycle; 33-bit partial remainder.
  - Decrement counter each cycle. At counter==0, go to FIX after this final iteration (32 iterations total).
- FIX:
  - Apply two's-complement negation per the sign flags: 64-bit for products, 32-bit for quotient/remainder.
  - Select the output: MUL → low word; MULH/MULHSU/MULHU → high word; DIV/DIVU → quotient; REM/REMU → remainder.
  - Register the selected word into result. Next state DONE.
- DONE: done=1 for exactly this cycle. Next state IDLE unless start=1, in which case a new op is accepted exactly as from IDLE.
- Latency, with start sampled at edge 0:
  - normal op: done high in the cycle following edge 33 (34 cycles);
  - special divide case: done high in the cycle following edge 0 (1 cycle).
- start while busy=1: ignored. Captured operands are unaffected by srcA/srcB/funct3 changes during CALC/FIX.
- MUL result is identical for signed and unsigned interpretation; MUL takes no sign fix.
- No overflow or exception flags; RV32M semantics only.

Decomposition:
- Shared package mdu_pkg:
  - mdu_op_t enum over the funct3 encodings;
  - mdu_state_t enum {IDLE, CALC, FIX, DONE};
  - constants DIV0_QUOT=32'hFFFFFFFF and INT_MIN=32'h80000000.
- Single module; no sub-module needed. The shared magnitude/negate logic is a package function, not a separate instance.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3) → result 0xFFFFFFEB; busy high from cycle 1 through 33; done high only in cycle 34.
- Upper-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide/remainder:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF;
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with done one cycle after start and busy never asserted:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM 0x80000000/0xFFFFFFFF → 0.
- Handshake:
  - DIVU 100/7 started; start re-pulsed at cycle 10 with MUL 3×3 → ignored; result 14.
  - start asserted in the DONE cycle with MUL 3×3 → accepted; result 9 with done 34 cycles later.
- RST asserted asynchronously mid-CALC (counter=20) → busy, done, result go to 0 before the next CLK edge. After release, DIV 9/3 → 3 with normal latency.

Source files
------------

// File: rtl/rv32m_mdu_pkg.sv
// rtl/rv32m_mdu_pkg.sv - shared types, constants and sign helpers for the RV32M multiply/divide unit
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // Used both to take magnitudes on capture and to restore signs in FIX.
  function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] x, input logic neg);
    return neg ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/rv32m_mdu_if.sv
// rtl/rv32m_mdu_if.sv - request/response bundle between the control unit and the multiply/divide unit
interface rv32m_mdu_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, srcA, srcB,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, srcA, srcB,
    output busy, done, result
  );
endinterface

// File: rtl/rv32m_mdu.sv
// rtl/rv32m_mdu.sv - iterative radix-2 RV32M multiply/divide unit, one bit per clock
module rv32m_mdu #(
  parameter int XLEN = 32
) (
  input logic         CLK,
  input logic         RST,
  rv32m_mdu_if.slave  bus
);
  import mdu_pkg::*;

  mdu_state_t        state_q, state_d;
  mdu_op_t           op_q, op_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              sgn_pq_q, sgn_pq_d;
  logic              sgn_r_q, sgn_r_d;
  logic [XLEN-1:0]   result_q, result_d;

  mdu_op_t         op_in;
  logic            accept, special, div0, ovf, a_sgn_en, b_sgn_en, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_shift, div_diff;
  logic [2*XLEN-1:0] prod;

  assign op_in    = mdu_op_t'(bus.funct3);
  assign accept   = bus.start && (state_q == IDLE || state_q == DONE);
  assign a_sgn_en = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn_en = op_in inside {OP_MULH, OP_DIV, OP_REM};
  assign sa       = bus.srcA[XLEN-1] & a_sgn_en;
  assign sb       = bus.srcB[XLEN-1] & b_sgn_en;
  assign mag_a    = cond_neg32(bus.srcA, sa);
  assign mag_b    = cond_neg32(bus.srcB, sb);
  assign div0     = bus.funct3[2] && (bus.srcB == '0);
  assign ovf      = (op_in == OP_DIV || op_in == OP_REM) &&
                    (bus.srcA == INT_MIN) && (bus.srcB == DIV0_QUOT);
  assign special  = div0 | ovf;

  // Multiply: add multiplicand into the upper half when the current multiplier bit is set, then shift right.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  // Divide: acc low word shifts dividend bits out and quotient bits in; borrow bit decides restore.
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_shift - {2'b00, opb_q};
  assign prod      = cond_neg64(acc_q, sgn_pq_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = special ? DONE : CALC;
        else        state_d = IDLE;
      end
      CALC:    state_d = (cnt_q == 5'd0) ? FIX : CALC;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == CALC) || (state_q == FIX);
    bus.done = (state_q == DONE);
  end

  assign bus.result = result_q;

  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    sgn_pq_d = sgn_pq_q;
    sgn_r_d  = sgn_r_q;
    result_d = result_q;
    if (accept) begin
      op_d     = op_in;
      cnt_d    = 5'd31;
      sgn_pq_d = sa ^ sb;
      sgn_r_d  = sa;
      rem_d    = '0;
      if (bus.funct3[2]) begin
        acc_d = {{XLEN{1'b0}}, mag_a};
        opb_d = mag_b;
      end else begin
        acc_d = {{XLEN{1'b0}}, mag_b};
        opb_d = mag_a;
      end
      if (div0) begin
        result_d = bus.funct3[1] ? bus.srcA : DIV0_QUOT;
      end else if (ovf) begin
        result_d = bus.funct3[1] ? '0 : INT_MIN;
      end
    end else if (state_q == CALC) begin
      cnt_d = cnt_q - 5'd1;
      if (op_q[2]) begin
        rem_d = div_diff[XLEN+1] ? div_shift[XLEN:0] : div_diff[XLEN:0];
        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN+1]};
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end else if (state_q == FIX) begin
      case (op_q)
        OP_MUL:                      result_d = acc_q[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:             result_d = cond_neg32(acc_q[XLEN-1:0], sgn_pq_q);
        default:                     result_d = cond_neg32(rem_q[XLEN-1:0], sgn_r_q);
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      sgn_pq_q <= 1'b0;
      sgn_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      sgn_pq_q <= sgn_pq_d;
      sgn_r_q  <= sgn_r_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_rv32m_mdu.sv
// tb/tb_rv32m_mdu.sv - directed self-checking bench for rv32m_mdu
module tb_rv32m_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rv32m_mdu_if #(.XLEN(32)) bus ();

  rv32m_mdu #(.XLEN(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Starts one op at the current negedge and reports in which cycle done appeared.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int busy_cyc, output logic [31:0] res);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.srcA   = a;
    bus.srcB   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_cyc  = 0;
    busy_cyc  = 0;
    res       = 32'hDEAD_BEEF;
    for (int n = 1; n <= 60 && done_cyc == 0; n++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cyc = n;
        res      = bus.result;
      end
    end
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.srcA   = '0;
    bus.srcB   = '0;
    rst        = 1'b1;
    #2;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int dc, bc;
    logic [31:0] r;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, dc, bc, r);
    checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h expected ffffffeb", r); end
    checks++; if (dc !== 34) begin errors++; $display("FAIL mul_done_cycle: got %0d expected 34", dc); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 33", bc); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_mul_high();
    logic [2:0]  fs [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] as [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int dc, bc;
    logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      run_op(fs[i], as[i], bs[i], dc, bc, r);
      checks++; if (r !== es[i]) begin errors++; $display("FAIL mulhi_result[%0d]: got %h expected %h", i, r, es[i]); end
      checks++; if (dc !== 34) begin errors++; $display("FAIL mulhi_done_cycle[%0d]: got %0d expected 34", i, dc); end
      @(negedge clk);
    end
  endtask

  task automatic test_divide();
    logic [2:0]  fs [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] es [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int dc, bc;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      run_op(fs[i], as[i], bs[i], dc, bc, r);
      checks++; if (r !== es[i]) begin errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, r, es[i]); end
      checks++; if (dc !== 34) begin errors++; $display("FAIL div_done_cycle[%0d]: got %0d expected 34", i, dc); end
      @(negedge clk);
    end
  endtask

  task automatic test_special();
    logic [2:0]  fs [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] as [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int dc, bc;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      run_op(fs[i], as[i], bs[i], dc, bc, r);
      checks++; if (r !== es[i]) begin errors++; $display("FAIL special_result[%0d]: got %h expected %h", i, r, es[i]); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL special_done_cycle[%0d]: got %0d expected 1", i, dc); end
      checks++; if (bc !== 0) begin errors++; $display("FAIL special_busy_cycles[%0d]: got %0d expected 0", i, bc); end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int dc = 0;
    logic [31:0] r = 32'hDEAD_BEEF;
    bus.start  = 1'b1;
    bus.funct3 = 3'b101;
    bus.srcA   = 32'd100;
    bus.srcB   = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 60 && dc == 0; n++) begin
      @(negedge clk);
      if (bus.done) begin
        dc = n;
        r  = bus.result;
      end
      if (n == 10) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.srcA   = 32'd3;
        bus.srcB   = 32'd3;
      end else if (n == 11) begin
        bus.start = 1'b0;
        bus.srcA  = 32'h1234_5678;
      end
    end
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL ignore_result: got %h expected 0000000e", r); end
    checks++; if (dc !== 34) begin errors++; $display("FAIL ignore_done_cycle: got %0d expected 34", dc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dc, bc;
    logic [31:0] r;
    run_op(3'b101, 32'd100, 32'd7, dc, bc, r);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL b2b_first_result: got %h expected 0000000e", r); end
    run_op(3'b000, 32'd3, 32'd3, dc, bc, r);
    checks++; if (r !== 32'd9) begin errors++; $display("FAIL b2b_second_result: got %h expected 00000009", r); end
    checks++; if (dc !== 34) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 34", dc); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 33", bc); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int dc, bc;
    logic [31:0] r;
    bus.start  = 1'b1;
    bus.funct3 = 3'b011;
    bus.srcA   = 32'hFFFF_FFFF;
    bus.srcB   = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL areset_busy_before: got %b expected 1", bus.busy); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b expected 0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL areset_result: got %h expected 00000000", bus.result); end
    #1;
    rst = 1'b0;
    @(negedge clk);
    run_op(3'b100, 32'd9, 32'd3, dc, bc, r);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL areset_div_result: got %h expected 00000003", r); end
    checks++; if (dc !== 34) begin errors++; $display("FAIL areset_div_done_cycle: got %0d expected 34", dc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_divide();
    test_special();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
